// File: rtl/lbsmm_pkg.sv
// Shared definitions for the sign-magnitude dot-product block:
// the FSM state encoding and the accumulator saturation limits.
package lbsmm_pkg;

    typedef enum logic [1:0] {
        ST_ACC   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Widest accumulator the limit helper can describe.
    localparam int SAT_MAX_W = 64;

    // Two's complement bound of an acc_w-bit accumulator; the caller keeps the low acc_w bits.
    function automatic logic signed [SAT_MAX_W-1:0] sat_limit(input int acc_w, input logic neg);
        logic signed [SAT_MAX_W-1:0] one;
        one = 1;
        if (neg) begin
            return -(one <<< (acc_w - 1));
        end
        return (one <<< (acc_w - 1)) - one;
    endfunction

endpackage

// File: rtl/lbsmm_mag_mul.sv
// Combinational sign-magnitude multiplier: shift-and-add over the magnitude bits,
// with any zero-magnitude product forced to +0.
module lbsmm_mag_mul #(
    parameter int W = 4
) (
    input  logic [W-1:0]       a,
    input  logic [W-1:0]       b,
    output logic               sign,
    output logic [2*(W-1)-1:0] mag
);
    localparam int MW = W - 1;
    localparam int PW = 2 * MW;

    logic [MW-1:0] a_mag;
    logic [MW-1:0] b_mag;
    logic [PW-1:0] part [MW+1];

    assign a_mag   = a[W-2:0];
    assign b_mag   = b[W-2:0];
    assign part[0] = '0;

    // Running sum of partial products, one adder per magnitude bit of b.
    generate
        for (genvar gi = 0; gi < MW; gi++) begin : g_pp
            assign part[gi+1] = part[gi] + (b_mag[gi] ? (PW'(a_mag) << gi) : '0);
        end
    endgenerate

    assign mag  = part[MW];
    assign sign = (a[W-1] ^ b[W-1]) & (|part[MW]);

endmodule

// File: rtl/lbsmm_dot.sv
// Streaming sign-magnitude dot product: two-stage multiply/accumulate with a
// saturating two's complement accumulator and a valid/ready result handshake.
module lbsmm_dot
    import lbsmm_pkg::*;
#(
    parameter int W     = 4,
    parameter int LEN   = 8,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_last,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_sat
);
    localparam int PW = 2 * (W - 1);
    localparam int CW = $clog2(LEN);

    localparam logic [SAT_MAX_W-1:0] LIM_HI_FULL = sat_limit(ACC_W, 1'b0);
    localparam logic [SAT_MAX_W-1:0] LIM_LO_FULL = sat_limit(ACC_W, 1'b1);
    localparam logic [ACC_W-1:0]     LIM_HI      = LIM_HI_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     LIM_LO      = LIM_LO_FULL[ACC_W-1:0];
    localparam logic [CW-1:0]        LAST_IDX    = CW'(LEN - 1);

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic            s1_valid_reg;
    logic            s1_sign_reg;
    logic [PW-1:0]   s1_mag_reg;
    logic [ACC_W-1:0] acc_reg;
    logic            sat_reg;

    logic            mul_sign;
    logic [PW-1:0]   mul_mag;
    logic            accept;
    logic            closing;
    logic            drain;
    logic [ACC_W:0]  mag_ext;
    logic [ACC_W:0]  prod_ext;
    logic [ACC_W:0]  sum_ext;
    logic            ovf;
    logic [ACC_W-1:0] acc_next;

    lbsmm_mag_mul #(.W(W)) u_mag_mul (
        .a    (a),
        .b    (b),
        .sign (mul_sign),
        .mag  (mul_mag)
    );

    assign accept  = in_valid && (state_reg == ST_ACC);
    assign closing = accept && (in_last || count_reg == LAST_IDX);
    assign drain   = out_valid && out_ready;

    // One guard bit above the accumulator exposes overflow of the signed add.
    assign mag_ext  = (ACC_W + 1)'(s1_mag_reg);
    assign prod_ext = s1_sign_reg ? -mag_ext : mag_ext;
    assign sum_ext  = {acc_reg[ACC_W-1], acc_reg} + prod_ext;
    assign ovf      = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    assign acc_next = ovf ? (sum_ext[ACC_W] ? LIM_LO : LIM_HI) : sum_ext[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_ACC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        unique case (state_reg)
            ST_ACC: begin
                in_ready = 1'b1;
                if (in_valid && (in_last || count_reg == LAST_IDX)) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = ST_ACC;
                end
            end
            default: begin
                state_next = ST_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg    <= '0;
            s1_valid_reg <= 1'b0;
            s1_sign_reg  <= 1'b0;
            s1_mag_reg   <= '0;
            acc_reg      <= '0;
            sat_reg      <= 1'b0;
        end else begin
            s1_valid_reg <= accept;
            if (accept) begin
                s1_sign_reg <= mul_sign;
                s1_mag_reg  <= mul_mag;
            end
            if (drain) begin
                acc_reg   <= '0;
                sat_reg   <= 1'b0;
                count_reg <= '0;
            end else begin
                if (s1_valid_reg) begin
                    acc_reg <= acc_next;
                    if (ovf) begin
                        sat_reg <= 1'b1;
                    end
                end
                // The closing pair leaves the count in place; only the handshake rewinds it.
                if (accept && !closing) begin
                    count_reg <= count_reg + CW'(1);
                end
            end
        end
    end

    assign out_data = acc_reg;
    assign out_sat  = sat_reg;

endmodule

// File: tb/tb_lbsmm_dot.sv
// Bench for lbsmm_dot: a 16-bit and an 8-bit accumulator instance share one stimulus
// stream and are checked every cycle against an integer dot-product model.
module tb_lbsmm_dot;
    localparam int W   = 4;
    localparam int LEN = 8;
    localparam int AW  = 16;
    localparam int AW8 = 8;
    localparam int NV  = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;

    logic in_ready, out_valid, out_sat;
    logic in_ready8, out_valid8, out_sat8;
    logic [AW-1:0]  out_data;
    logic [AW8-1:0] out_data8;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    always #5 clk = ~clk;
    always @(posedge clk) edge_no++;

    lbsmm_dot #(.W(W), .LEN(LEN), .ACC_W(AW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat)
    );

    lbsmm_dot #(.W(W), .LEN(LEN), .ACC_W(AW8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8), .in_last(in_last),
        .a(a), .b(b), .out_valid(out_valid8), .out_ready(out_ready),
        .out_data(out_data8), .out_sat(out_sat8)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sm_val(input logic [W-1:0] x);
        int m;
        m = int'(x[W-2:0]);
        return x[W-1] ? -m : m;
    endfunction

    function automatic int clamp(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        return (v > hi) ? hi : ((v < lo) ? lo : v);
    endfunction

    // Model: expected outputs after each edge, derived from the arithmetic rules.
    bit m_ready = 1'b1;
    bit m_flush = 1'b0;
    bit m_valid = 1'b0;
    int m_cnt = 0;
    int m_acc16 = 0;
    int m_acc8 = 0;
    bit m_sat16 = 1'b0;
    bit m_sat8 = 1'b0;
    int r_data16 = 0;
    int r_data8 = 0;
    bit r_sat16 = 1'b0;
    bit r_sat8 = 1'b0;
    int close_edge = 0;

    always @(negedge clk) begin
        int p;
        int s;
        if (rst) begin
            chk("rst_in_ready", in_ready, 1);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_out_sat", out_sat, 0);
            chk("rst_in_ready8", in_ready8, 1);
            chk("rst_out_data8", out_data8, 0);
            m_ready = 1'b1; m_flush = 1'b0; m_valid = 1'b0; m_cnt = 0;
            m_acc16 = 0; m_acc8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0;
        end else begin
            chk("in_ready", in_ready, m_ready);
            chk("in_ready8", in_ready8, m_ready);
            chk("out_valid", out_valid, m_valid);
            chk("out_valid8", out_valid8, m_valid);
            if (m_valid) begin
                chk("out_data", $signed(out_data), r_data16);
                chk("out_sat", out_sat, r_sat16);
                chk("out_data8", $signed(out_data8), r_data8);
                chk("out_sat8", out_sat8, r_sat8);
            end
            if (m_valid && out_ready) begin
                m_valid = 1'b0;
                m_ready = 1'b1;
            end else if (m_flush) begin
                m_flush = 1'b0;
                m_valid = 1'b1;
            end else if (m_ready && in_valid) begin
                p = sm_val(a) * sm_val(b);
                s = clamp(m_acc16 + p, AW);
                if (s != m_acc16 + p) m_sat16 = 1'b1;
                m_acc16 = s;
                s = clamp(m_acc8 + p, AW8);
                if (s != m_acc8 + p) m_sat8 = 1'b1;
                m_acc8 = s;
                if (in_last || m_cnt == LEN - 1) begin
                    r_data16 = m_acc16; r_sat16 = m_sat16;
                    r_data8 = m_acc8;   r_sat8 = m_sat8;
                    m_acc16 = 0; m_acc8 = 0; m_sat16 = 1'b0; m_sat8 = 1'b0; m_cnt = 0;
                    m_ready = 1'b0;
                    m_flush = 1'b1;
                    close_edge = edge_no + 1;
                end else begin
                    m_cnt++;
                end
            end
        end
    end

    int cap16 [NV];
    int cap8 [NV];
    bit csat16 [NV];
    bit csat8 [NV];
    int vseen = 0;

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic last);
        bit ok;
        int t;
        a = av; b = bv; in_last = last; in_valid = 1'b1;
        ok = 1'b0;
        t = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!ok && t < 50);
        if (!ok) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 50 cycles");
        end
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Collect one result; pairs offered meanwhile must be ignored outside ACC.
    task automatic recv(input int hold, input int k);
        int t;
        out_ready = (hold == 0);
        a = 4'b0111; b = 4'b0111; in_last = 1'b1; in_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 50);
        if (!out_valid) begin
            n_vec++; n_err++;
            $display("FAIL recv_timeout: out_valid stayed 0, expected 1 within 50 cycles");
        end
        vseen = edge_no;
        if (hold > 0) begin
            repeat (hold) @(posedge clk);
            #1 out_ready = 1'b1;
            @(negedge clk);
        end
        cap16[k] = $signed(out_data);
        cap8[k] = $signed(out_data8);
        csat16[k] = out_sat;
        csat8[k] = out_sat8;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    // Hand-computed results per vector.
    int exp16 [NV] = '{392, -15, 6, -392, 84, 23, -48};
    bit exps16 [NV] = '{0, 0, 0, 0, 0, 0, 0};
    int exp8 [NV] = '{127, -15, 6, -128, 84, 23, -48};
    bit exps8 [NV] = '{1, 0, 0, 1, 0, 0, 0};

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // v0: eight 7x7 pairs with an idle in_last pulse mid-vector.
        for (int i = 0; i < 3; i++) send(4'b0111, 4'b0111, 1'b0);
        in_last = 1'b1;
        @(posedge clk);
        #1 in_last = 1'b0;
        for (int i = 3; i < 8; i++) send(4'b0111, 4'b0111, 1'b0);
        recv(0, 0);
        chk("latency_edges", vseen + 1 - close_edge, 2);

        // v1: (-3)*(+5) closed early by in_last.
        send(4'b1011, 4'b0101, 1'b1);
        recv(0, 1);

        // v2: -0 operand contributes +0.
        send(4'b1000, 4'b1101, 1'b0);
        send(4'b0010, 4'b0011, 1'b1);
        recv(0, 2);

        // v3: eight (-7)*7 pairs.
        for (int i = 0; i < 8; i++) send(4'b1111, 4'b0111, 1'b0);
        recv(0, 3);

        // v4: k*3 for k=0..7, result held with out_ready low.
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] av;
            av = W'(i);
            send(av, 4'b0011, 1'b0);
        end
        recv(5, 4);

        // v5: starts on the cycle right after the handshake.
        send(4'b0101, 4'b0101, 1'b0);
        send(4'b1001, 4'b0010, 1'b1);
        recv(0, 5);

        // v6: reset mid-vector, then a fresh vector of 3*(-2).
        for (int i = 0; i < 3; i++) send(4'b0111, 4'b0111, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 8; i++) send(4'b0011, 4'b1010, 1'b0);
        recv(0, 6);

        for (int k = 0; k < NV; k++) begin
            chk($sformatf("pin_v%0d_data16", k), cap16[k], exp16[k]);
            chk($sformatf("pin_v%0d_sat16", k), csat16[k], exps16[k]);
            chk($sformatf("pin_v%0d_data8", k), cap8[k], exp8[k]);
            chk($sformatf("pin_v%0d_sat8", k), csat8[k], exps8[k]);
        end

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        n_vec++;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lbsmm_dot.md
LBSMM_DOT -- requirements
Module: lbsmm_dot

Interface
REQ-001 SHALL have parameter W, default 4, meaning operand width including the sign bit (sign-magnitude, legal range 3..8).
REQ-002 SHALL have parameter LEN, default 8, meaning the number of products per dot product (legal range 2..256).
REQ-003 SHALL have parameter ACC_W, default 16, meaning the accumulator and result width (two's complement, ACC_W >= 2*(W-1)+1).
REQ-004 Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block accepts an operand pair.
- in_last  in  1  marks the final pair of the current vector (early termination).
- a  in  W  operand A, sign-magnitude: MSB is the sign, the rest is the magnitude.
- b  in  W  operand B, sign-magnitude.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_data  out  ACC_W  dot-product result, two's complement.
- out_sat  out  1  result was clamped.

Function
REQ-005 SHALL accept a pair only when in_valid && in_ready are both high on a rising clk edge.
REQ-006 SHALL compute each product magnitude as a[W-2:0]*b[W-2:0] (2*(W-1) bits) and the product sign as a[W-1]^b[W-1].
REQ-007 SHALL treat any product of magnitude zero, including -0 operands, as +0.
REQ-008 SHALL pipeline in two stages: stage 1 registers the product magnitude and sign; stage 2 adds the signed product into the accumulator.
REQ-009 SHALL implement three states: ACC, FLUSH and HOLD.
- ACC: in_ready=1.
- FLUSH: in_ready=0, lasts one cycle while stage 1 drains into the accumulator.
- HOLD: in_ready=0, out_valid=1.
REQ-010 SHALL go ACC->FLUSH on the accepted pair that has count==LEN-1 or in_last=1, whichever comes first, and SHALL then go FLUSH->HOLD.
REQ-011 SHALL go HOLD->ACC on out_valid && out_ready, clearing the accumulator, the element count and out_sat in that same edge.
REQ-012 SHALL assert out_valid exactly 2 cycles after the edge that accepts the closing pair.
REQ-013 SHALL hold out_data and out_sat stable while out_valid=1 and out_ready=0.
REQ-014 SHALL saturate each accumulation to the range [-(2^(ACC_W-1)), 2^(ACC_W-1)-1] and SHALL set out_sat sticky for the rest of the vector once any clamp occurs.
REQ-015 SHALL keep the element counter at clog2(LEN) bits, wrapping to 0 only through REQ-011.
REQ-016 SHALL ignore in_last whenever in_valid is low.
REQ-017 SHALL ignore in_valid outside ACC, with no state change.

Reset
REQ-018 SHALL, on rst=1 at any time including mid-vector, immediately clear the state to ACC, and clear the accumulator, the counter, the stage-1 registers, out_data, out_sat and out_valid to 0.
REQ-019 SHALL drive in_ready=1 during reset and after its release.
REQ-020 SHALL accept a pair on the first clk edge after rst deasserts.

Structure
REQ-021 SHALL place the state encoding (ACC/FLUSH/HOLD) and a saturate-limit helper in a shared package lbsmm_pkg.
REQ-022 SHALL contain exactly one sub-module, lbsmm_mag_mul, which is a combinational parametrised sign-magnitude multiplier producing {sign, magnitude} with the zero rule of REQ-007.
REQ-023 SHALL derive everything width-dependent from W, LEN and ACC_W, with no hard-coded widths.

Verification
REQ-024 W=4, LEN=8: eight pairs 4'b0111 x 4'b0111 -> out_data=392, out_sat=0, out_valid at accept+2.
REQ-025 W=4: a=4'b1011 (-3), b=4'b0101 (+5), in_last=1 -> out_data=-15 (16'hFFF1).
REQ-026 a=4'b1000 (-0) x b=4'b1101 (-5), then a=4'b0010 x b=4'b0011 with in_last -> out_data=6 (the -0 product contributes +0).
REQ-027 ACC_W=8: eight pairs 7x7 -> out_data=127, out_sat=1; eight pairs (-7)x7 -> out_data=-128, out_sat=1.
REQ-028 Result present with out_ready held low 5 cycles -> out_data stable, in_ready=0 throughout, new vector accepted the cycle after the handshake.
REQ-029 rst pulsed after 3 of 8 pairs -> all outputs 0 and in_ready=1; a fresh 8-pair vector then gives the correct sum with no carry-over.
